// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA command path: opcodes, FSM encoding and default widths.
package rsa_pkg;

  localparam int RSA_DATA_W = 1024;

  localparam logic [1:0] CMD_READ    = 2'd0;
  localparam logic [1:0] CMD_COMPUTE = 2'd1;
  localparam logic [1:0] CMD_WRITE   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_DISPATCH,
    S_WAIT_CORE,
    S_TX,
    S_DONE
  } state_e;

endpackage

// File: rtl/rsa_cmd_scheduler_if.sv
// ARM-side command and data handshakes of the RSA scheduler.
interface rsa_cmd_scheduler_if
  import rsa_pkg::*;
#(
  parameter int DATA_W = RSA_DATA_W
);
  logic [31:0]       cmd;
  logic              cmd_valid;
  logic              done;
  logic              done_read;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout;

  modport master (
    output cmd, cmd_valid, done_read, din_valid, din, dout_ready,
    input  done, din_ready, dout_valid, dout
  );

  modport slave (
    input  cmd, cmd_valid, done_read, din_valid, din, dout_ready,
    output done, din_ready, dout_valid, dout
  );
endinterface

// File: rtl/rsa_rr_pick.sv
// Combinational round-robin pick: first non-busy entry scanning upward from ptr_i with wrap.
module rsa_rr_pick #(
  parameter  int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] busy_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);
  int c;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr_i) + i;
      if (c >= N) c = c - N;
      if (!found_o && !busy_i[W'(c)]) begin
        found_o = 1'b1;
        idx_o   = W'(c);
      end
    end
  end
endmodule

// File: rtl/rsa_cmd_scheduler.sv
// Command sequencer: decodes ARM commands, holds operand/result, dispatches COMPUTE round-robin to cores.
module rsa_cmd_scheduler
  import rsa_pkg::*;
#(
  parameter int DATA_W    = RSA_DATA_W,
  parameter int NUM_CORES = 2,
  parameter int TIMEOUT   = 2**20
) (
  input  logic                          clk,
  input  logic                          resetn,
  rsa_cmd_scheduler_if.slave            arm,
  output logic [DATA_W-1:0]             core_operand,
  output logic [NUM_CORES-1:0]          core_start,
  input  logic [NUM_CORES-1:0]          core_busy,
  input  logic [NUM_CORES-1:0]          core_done,
  input  logic [NUM_CORES*DATA_W-1:0]   core_result,
  output logic [3:0]                    leds
);
  localparam int W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      operand_q, operand_d;
  logic [DATA_W-1:0]      result_q, result_d;
  logic [W-1:0]           rr_q, rr_d;
  logic [W-1:0]           cur_q, cur_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [NUM_CORES-1:0]   start_q, start_d;
  logic                   done_q;
  logic [2:0]             led_q;
  logic                   pick_found;
  logic [W-1:0]           pick_idx;
  logic [DATA_W-1:0]      res_arr [NUM_CORES];
  logic                   unused_cmd;

  assign unused_cmd = ^arm.cmd[31:2];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_res
    assign res_arr[k] = core_result[k*DATA_W +: DATA_W];
  end

  rsa_rr_pick #(.N(NUM_CORES)) u_pick (
    .busy_i  (core_busy),
    .ptr_i   (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    result_d  = result_q;
    rr_d      = rr_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    start_d   = '0;
    case (state_q)
      S_IDLE: if (arm.cmd_valid) begin
        err_d = 1'b0;
        case (arm.cmd[1:0])
          CMD_READ:    state_d = S_RX;
          CMD_COMPUTE: state_d = S_DISPATCH;
          CMD_WRITE:   state_d = S_TX;
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_RX: if (arm.din_valid) begin
        operand_d = arm.din;
        state_d   = S_DONE;
      end
      S_DISPATCH: if (pick_found) begin
        start_d = NUM_CORES'(1) << pick_idx;
        cur_d   = pick_idx;
        rr_d    = (pick_idx == W'(NUM_CORES-1)) ? '0 : pick_idx + W'(1);
        cnt_d   = '0;
        state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion in the timeout cycle still counts as success.
        if (core_done[cur_q]) begin
          result_d = res_arr[cur_q];
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_TX:   if (arm.dout_ready) state_d = S_DONE;
      S_DONE: if (arm.done_read)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      operand_q <= '0;
      result_q  <= '0;
      rr_q      <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= '0;
      done_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      rr_q      <= rr_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      start_q   <= start_d;
      done_q    <= (state_d == S_DONE);
      led_q     <= {state_d == S_TX, state_d == S_WAIT_CORE, state_d == S_RX};
    end
  end

  assign arm.done       = done_q;
  assign arm.din_ready  = (state_q == S_RX);
  assign arm.dout_valid = (state_q == S_TX);
  assign arm.dout       = result_q;
  assign core_operand   = operand_q;
  assign core_start     = start_q;
  assign leds           = {err_q, led_q};
endmodule

// File: tb/tb_rsa_cmd_scheduler.sv
// Directed bench for rsa_cmd_scheduler with a two-core model answering 50 cycles after start.
module tb_rsa_cmd_scheduler;
  import rsa_pkg::*;

  localparam int DW = 1024;
  localparam int NC = 2;
  localparam int TO = 64;

  localparam logic [DW-1:0] OP1 = 1024'h0123456789abcdef << 768;
  localparam logic [DW-1:0] OP2 = {16{64'hfeed_face_cafe_beef}};
  localparam logic [DW-1:0] R0  = {8{128'h0000_1111_2222_3333_4444_5555_6666_7777}};
  localparam logic [DW-1:0] R1  = {8{128'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rsa_cmd_scheduler_if #(.DATA_W(DW)) arm ();

  logic [DW-1:0]    core_operand;
  logic [NC-1:0]    core_start;
  logic [NC-1:0]    core_busy;
  logic [NC-1:0]    core_done = '0;
  logic [NC*DW-1:0] core_result;
  logic [3:0]       leds;
  logic             core_en;
  int               cd_cnt [NC] = '{0, 0};
  int               checks = 0;
  int               errors = 0;

  assign core_result = {R1, R0};

  rsa_cmd_scheduler #(.DATA_W(DW), .NUM_CORES(NC), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .arm          (arm.slave),
    .core_operand (core_operand),
    .core_start   (core_start),
    .core_busy    (core_busy),
    .core_done    (core_done),
    .core_result  (core_result),
    .leds         (leds)
  );

  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (core_start[k] && core_en) cd_cnt[k] <= 50;
      else if (cd_cnt[k] > 0)       cd_cnt[k] <= cd_cnt[k] - 1;
      core_done[k] <= (cd_cnt[k] == 1);
    end
  end

  function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < DW/128; i++)
      if (a[i*128 +: 128] !== b[i*128 +: 128]) return i;
    return 0;
  endfunction

  task automatic issue_cmd(input logic [1:0] op);
    arm.cmd       = {30'd0, op};
    arm.cmd_valid = 1'b1;
    @(negedge clk);
    arm.cmd_valid = 1'b0;
  endtask

  task automatic ack_done();
    arm.done_read = 1'b1;
    @(negedge clk);
    arm.done_read = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({arm.done, arm.din_ready, arm.dout_valid, core_start, leds} !== 9'd0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0", {arm.done, arm.din_ready, arm.dout_valid, core_start, leds});
    end
    checks++;
    if (arm.dout !== '0 || core_operand !== '0) begin
      errors++; $display("FAIL reset_data: dout/operand nonzero");
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [DW-1:0] exp;
    int w;
    exp = OP1;
    issue_cmd(CMD_READ);
    checks++;
    if (arm.din_ready !== 1'b1 || leds !== 4'b0001) begin
      errors++; $display("FAIL rx_state: din_ready %b leds %b expected 1 0001", arm.din_ready, leds);
    end
    arm.din = OP1; arm.din_valid = 1'b1;
    @(negedge clk);
    arm.din_valid = 1'b0;
    checks++;
    if (arm.done !== 1'b1 || leds !== 4'b0000) begin
      errors++; $display("FAIL rx_done: done %b leds %b expected 1 0000", arm.done, leds);
    end
    checks++;
    if (core_operand !== exp) begin
      w = first_diff(core_operand, exp); errors++;
      $display("FAIL rx_operand: word %0d got %h expected %h", w, core_operand[w*128 +: 128], exp[w*128 +: 128]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (arm.done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b expected 1", arm.done); end
    ack_done();
    checks++;
    if (arm.done !== 1'b0) begin errors++; $display("FAIL done_clear: got %b expected 0", arm.done); end
  endtask

  task automatic run_compute(input string nm, input logic [NC-1:0] exp_start, input logic [DW-1:0] exp_res);
    int n;
    int w;
    n = 0;
    checks++;
    if (core_start !== exp_start || leds[1] !== 1'b1) begin
      errors++; $display("FAIL %s_start: start %b leds1 %b expected %b 1", nm, core_start, leds[1], exp_start);
    end
    @(negedge clk);
    checks++;
    if (core_start !== '0) begin errors++; $display("FAIL %s_pulse: got %b expected 00", nm, core_start); end
    while (!arm.done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (arm.done !== 1'b1) begin errors++; $display("FAIL %s_timeout: done %b after %0d cycles expected 1", nm, arm.done, n); end
    checks++;
    if (arm.dout !== exp_res || leds[3] !== 1'b0) begin
      w = first_diff(arm.dout, exp_res); errors++;
      $display("FAIL %s_result: word %0d got %h err %b expected %h err 0", nm, w, arm.dout[w*128 +: 128], leds[3], exp_res[w*128 +: 128]);
    end
    ack_done();
  endtask

  task automatic test_compute_rr();
    core_en = 1'b1; core_busy = 2'b00;
    issue_cmd(CMD_COMPUTE); @(negedge clk);
    run_compute("rr0", 2'b01, R0);
    issue_cmd(CMD_COMPUTE); @(negedge clk);
    run_compute("rr1", 2'b10, R1);
  endtask

  task automatic test_busy();
    core_busy = 2'b01;
    issue_cmd(CMD_COMPUTE); @(negedge clk);
    run_compute("busy01", 2'b10, R1);
    core_busy = 2'b11;
    issue_cmd(CMD_COMPUTE);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (core_start !== 2'b00 || leds[1] !== 1'b0) begin
        errors++; $display("FAIL busy11_stall: start %b leds1 %b expected 00 0", core_start, leds[1]);
      end
    end
    core_busy = 2'b01;
    @(negedge clk);
    run_compute("busy_freed", 2'b10, R1);
    core_busy = 2'b00;
  endtask

  task automatic test_write();
    logic [DW-1:0] exp;
    exp = R1;
    issue_cmd(CMD_WRITE);
    arm.dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (arm.dout_valid !== 1'b1 || arm.dout !== exp || arm.done !== 1'b0 || leds[2] !== 1'b1) begin
        errors++; $display("FAIL tx_hold: cycle %0d valid %b done %b leds2 %b expected 1 0 1", i, arm.dout_valid, arm.done, leds[2]);
      end
      @(negedge clk);
    end
    arm.dout_ready = 1'b1;
    @(negedge clk);
    arm.dout_ready = 1'b0;
    checks++;
    if (arm.done !== 1'b1 || arm.dout_valid !== 1'b0) begin
      errors++; $display("FAIL tx_done: done %b valid %b expected 1 0", arm.done, arm.dout_valid);
    end
    ack_done();
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    core_en = 1'b0;
    issue_cmd(CMD_COMPUTE);
    while (!arm.done && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n !== 65) begin errors++; $display("FAIL to_latency: done after %0d cycles expected 65", n); end
    checks++;
    if (leds !== 4'b1000 || arm.dout !== R1) begin
      errors++; $display("FAIL to_err: leds %b result_kept %b expected 1000 1", leds, arm.dout === R1);
    end
    ack_done();
    checks++;
    if (leds[3] !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", leds[3]); end
    issue_cmd(CMD_READ);
    checks++;
    if (leds !== 4'b0001) begin errors++; $display("FAIL err_clear: got %b expected 0001", leds); end
    arm.din = OP2; arm.din_valid = 1'b1;
    @(negedge clk);
    arm.din_valid = 1'b0;
    ack_done();
  endtask

  task automatic test_reserved_and_abort();
    logic [DW-1:0] exp;
    int w;
    exp = OP1;
    issue_cmd(2'd3);
    checks++;
    if (arm.done !== 1'b1 || leds !== 4'b1000) begin
      errors++; $display("FAIL op3: done %b leds %b expected 1 1000", arm.done, leds);
    end
    ack_done();
    issue_cmd(CMD_READ);
    resetn = 1'b0; #1;
    checks++;
    if ({arm.done, arm.din_ready, arm.dout_valid, core_start, leds} !== 9'd0 || core_operand !== '0 || arm.dout !== '0) begin
      errors++; $display("FAIL abort_rx: ctl %b expected 0", {arm.done, arm.din_ready, arm.dout_valid, core_start, leds});
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    issue_cmd(CMD_COMPUTE);
    repeat (3) @(negedge clk);
    checks++;
    if (leds[1] !== 1'b1) begin errors++; $display("FAIL wait_entry: leds1 %b expected 1", leds[1]); end
    resetn = 1'b0; #1;
    checks++;
    if ({arm.done, arm.din_ready, arm.dout_valid, core_start, leds} !== 9'd0) begin
      errors++; $display("FAIL abort_wait: ctl %b expected 0", {arm.done, arm.din_ready, arm.dout_valid, core_start, leds});
    end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    issue_cmd(CMD_READ);
    checks++;
    if (arm.din_ready !== 1'b1) begin errors++; $display("FAIL post_rx: din_ready %b expected 1", arm.din_ready); end
    arm.din = OP1; arm.din_valid = 1'b1;
    @(negedge clk);
    arm.din_valid = 1'b0;
    checks++;
    if (arm.done !== 1'b1 || core_operand !== exp) begin
      w = first_diff(core_operand, exp); errors++;
      $display("FAIL post_read: done %b word %0d got %h expected %h", arm.done, w, core_operand[w*128 +: 128], exp[w*128 +: 128]);
    end
    ack_done();
  endtask

  initial begin
    arm.cmd = '0; arm.cmd_valid = 1'b0; arm.done_read = 1'b0;
    arm.din = '0; arm.din_valid = 1'b0; arm.dout_ready = 1'b0;
    core_busy = '0; core_en = 1'b1;
    test_reset();
    test_read();
    test_compute_rr();
    test_busy();
    test_write();
    test_timeout();
    test_reserved_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
